if_fetch: RTL and testbench

- Instruction-fetch stage sitting directly upstream of the byte-serial memory controller's IF port.
- Holds the PC and a direct-mapped, one-word-per-line instruction cache.
- On a hit it delivers one instruction per cycle to decode. On a miss it issues a word read to the memory controller and fills the line when the controller signals done.
- Handles pipeline stall, branch/jump redirect, and arbitration loss to the MEM stage.

---
 rtl/if_fetch.sv | 179 +++++++++++++++++
 tb/tb_if_fetch.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Purpose  : Instruction-fetch stage. Holds the PC and a direct-mapped,
//            one-word-per-line instruction cache. Hits deliver one
//            instruction per cycle to decode; misses issue a word read to
//            the memory controller and fill the line when it reports done.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            rdy             - global ready, 0 freezes all state
//            stall_i         - decode cannot accept, output register holds
//            jump_i/jump_addr_i - redirect request and target
//            mem_req_i       - MEM stage owns memctrl this cycle
//            mc_busy_i/mc_done_i/mc_data_i - memctrl handshake and data
//            if_re_o/if_addr_o - fetch read request to memctrl
//            inst_o/pc_o/valid_o - instruction to decode
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch #(
  parameter int                 ADDR_W   = 32,
  parameter int                 IDX_W    = 6,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              stall_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              mem_req_i,
  input  logic              mc_busy_i,
  input  logic              mc_done_i,
  input  logic [31:0]       mc_data_i,
  output logic              if_re_o,
  output logic [ADDR_W-1:0] if_addr_o,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              valid_o
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   fa_q, fa_d;
  logic                drop_q, drop_d;
  logic                valid_q, valid_d;
  logic [31:0]         inst_q, inst_d;
  logic [ADDR_W-1:0]   pco_q, pco_d;

  logic [LINES-1:0]    lv_q;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [31:0]         data_q [LINES];

  logic [IDX_W-1:0]    pc_idx, fa_idx;
  logic [TAG_W-1:0]    pc_tag, fa_tag;
  logic                hit;
  logic                accept;
  logic                fill;
  logic [ADDR_W-1:0]   jump_pc;
  logic                jump_lsb_unused;

  assign pc_idx  = pc_q[IDX_W+1:2];
  assign pc_tag  = pc_q[ADDR_W-1:IDX_W+2];
  assign fa_idx  = fa_q[IDX_W+1:2];
  assign fa_tag  = fa_q[ADDR_W-1:IDX_W+2];
  // Combinational array read: hit/miss is resolved in the lookup cycle.
  assign hit     = lv_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign accept  = !mc_busy_i && !mem_req_i;
  assign jump_pc = {jump_addr_i[ADDR_W-1:2], 2'b00};
  assign jump_lsb_unused = ^jump_addr_i[1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fa_d    = fa_q;
    drop_d  = drop_q;
    valid_d = valid_q;
    inst_d  = inst_q;
    pco_d   = pco_q;
    fill    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (jump_i) begin
          pc_d    = jump_pc;
          valid_d = 1'b0;
        end else if (hit) begin
          if (!stall_i) begin
            inst_d  = data_q[pc_idx];
            pco_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + ADDR_W'(4);
          end
        end else begin
          if (!stall_i) valid_d = 1'b0;
          fa_d    = pc_q;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // mc_done_i is not looked at here: it may belong to a MEM access.
        if (!stall_i) valid_d = 1'b0;
        if (accept) begin
          state_d = ST_WAIT;
          if (jump_i) begin
            // Request is now committed in memctrl; ride it out.
            pc_d    = jump_pc;
            valid_d = 1'b0;
            drop_d  = 1'b1;
          end
        end else if (jump_i) begin
          pc_d    = jump_pc;
          valid_d = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (!stall_i) valid_d = 1'b0;
        if (mc_done_i) begin
          // The word is correct for fa even if its fetch was abandoned.
          fill    = 1'b1;
          state_d = ST_RUN;
          drop_d  = 1'b0;
          pc_d    = drop_q ? pc_q : fa_q;
        end
        if (jump_i) begin
          pc_d    = jump_pc;
          valid_d = 1'b0;
          if (!mc_done_i) drop_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      fa_q    <= '0;
      drop_q  <= 1'b0;
      valid_q <= 1'b0;
      inst_q  <= '0;
      pco_q   <= '0;
      lv_q    <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fa_q    <= fa_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pco_q   <= pco_d;
      if (fill) lv_q[fa_idx] <= 1'b1;
    end
  end

  // Tag/data arrays need no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (!rst && rdy && fill) begin
      tag_q[fa_idx]  <= fa_tag;
      data_q[fa_idx] <= mc_data_i;
    end
  end

  assign if_re_o   = (state_q == ST_ISSUE);
  assign if_addr_o = (state_q == ST_ISSUE) ? fa_q : '0;
  assign inst_o    = inst_q;
  assign pc_o      = pco_q;
  assign valid_o   = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_if_fetch
// Purpose  : Self-checking bench for if_fetch with a 4-cycle memctrl model
//            and an expected-delivery scoreboard checked by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst, rdy, stall_i, jump_i, mem_req_i;
  logic [31:0] jump_addr_i;
  logic        mc_busy_i, mc_done_i;
  logic [31:0] mc_data_i;
  logic        if_re_o;
  logic [31:0] if_addr_o, inst_o, pc_o;
  logic        valid_o;

  int n_checks = 0;
  int n_errors = 0;

  if_fetch #(.ADDR_W(32), .IDX_W(6), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall_i(stall_i),
    .jump_i(jump_i), .jump_addr_i(jump_addr_i), .mem_req_i(mem_req_i),
    .mc_busy_i(mc_busy_i), .mc_done_i(mc_done_i), .mc_data_i(mc_data_i),
    .if_re_o(if_re_o), .if_addr_o(if_addr_o), .inst_o(inst_o),
    .pc_o(pc_o), .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  // Memory image: addr 0 -> 0x00000013, addr 0x40 -> 0x00400013, etc.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0000_0013 ^ {a[15:0], 16'h0000};
  endfunction

  // ---------------- memctrl model: done 4 cycles after accept -------------
  logic        mdl_busy = 1'b0, mdl_done = 1'b0, stale_done = 1'b0;
  logic [31:0] mdl_data = '0, mdl_addr = '0;
  int          mdl_cnt = 0;

  assign mc_busy_i = mdl_busy;
  assign mc_done_i = mdl_done | stale_done;
  assign mc_data_i = stale_done ? 32'hBAD0_BAD0 : mdl_data;

  always @(posedge clk) begin
    if (mdl_done) begin
      mdl_done <= 1'b0;
      mdl_busy <= 1'b0;
    end else if (mdl_busy) begin
      if (mdl_cnt == 1) begin
        mdl_done <= 1'b1;
        mdl_data <= mem_word(mdl_addr);
      end
      mdl_cnt <= mdl_cnt - 1;
    end else if (if_re_o && !mem_req_i) begin
      mdl_busy <= 1'b1;
      mdl_cnt  <= 3;
      mdl_addr <= if_addr_o;
    end
  end

  // ---------------- scoreboard and monitor --------------------------------
  logic [63:0] exp_q [$];
  logic        hold_s = 1'b1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({pc, mem_word(pc)});
  endtask

  always @(posedge clk) hold_s <= stall_i | ~rdy | rst;

  // A fresh delivery is valid_o=1 after an edge where the output was free to load.
  always @(negedge clk) begin
    if (valid_o && !hold_s) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_delivery actual pc=%h inst=%h required none", pc_o, inst_o);
      end else begin
        check("deliver_pc_inst", {pc_o, inst_o}, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ---------------------------------------------
  int deliv = 0;
  bit re_seen = 1'b0;

  task automatic step();
    bit h;
    h = stall_i | ~rdy | rst;
    @(posedge clk);
    #1;
    if (valid_o && !h) deliv++;
    if (if_re_o) re_seen = 1'b1;
  endtask

  task automatic wait_deliv(input string nm, input int target, input int budget);
    int k = 0;
    while (deliv < target && k < budget) begin
      step();
      k++;
    end
    check(nm, deliv, target);
  endtask

  task automatic jump_to(input logic [31:0] a);
    jump_i      = 1'b1;
    jump_addr_i = a;
    step();
    jump_i  = 1'b0;
    re_seen = 1'b0;
  endtask

  task automatic fetch(input string nm, input logic [31:0] a, input int n);
    int base;
    jump_to(a);
    for (int i = 0; i < n; i++) push_exp(a + 32'(4 * i));
    base = deliv;
    wait_deliv(nm, base + n, 60);
  endtask

  initial begin
    int  base, k;
    bit  done_seen;
    rst = 1'b1; rdy = 1'b1; stall_i = 1'b0; jump_i = 1'b0;
    jump_addr_i = '0; mem_req_i = 1'b0;
    step();
    step();
    check("rst_valid", valid_o, 0);
    check("rst_inst", inst_o, 0);
    check("rst_pc", pc_o, 0);
    check("rst_re", if_re_o, 0);
    check("rst_addr", if_addr_o, 0);

    // Cold start at RESET_PC
    push_exp(32'h0);
    base = deliv;
    rst = 1'b0;
    step();
    check("cold_re", if_re_o, 1);
    check("cold_addr", if_addr_o, 32'h0);
    k = 1;
    while (deliv < base + 1 && k < 40) begin
      step();
      k++;
    end
    check("cold_deliv", deliv, base + 1);
    check("cold_latency_ge7", (k >= 7), 1);

    // Second pass over 0 hits
    fetch("hit0_deliv", 32'h0, 1);
    check("hit0_no_re", re_seen, 0);

    // Arbitration loss at 0x40, stale done ignored in ISSUE
    mem_req_i = 1'b1;
    jump_to(32'h40);
    push_exp(32'h40);
    base = deliv;
    step();
    for (int i = 0; i < 3; i++) begin
      check("arb_re", if_re_o, 1);
      check("arb_addr", if_addr_o, 32'h40);
      if (i == 1) stale_done = 1'b1;
      step();
      stale_done = 1'b0;
    end
    check("arb_re_held", if_re_o, 1);
    mem_req_i = 1'b0;
    step();
    check("arb_accepted", if_re_o, 0);
    wait_deliv("arb_deliv", base + 1, 30);

    // Stall and rdy hold over cached 0x0/0x4/0x8
    fetch("warm_048", 32'h0, 3);
    jump_to(32'h0);
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
    base = deliv;
    step();
    check("stl_d0", deliv, base + 1);
    rdy = 1'b0;
    step();
    step();
    check("rdy_hold_pc", pc_o, 32'h0);
    check("rdy_hold_valid", valid_o, 1);
    rdy = 1'b1;
    step();
    check("stl_d4", pc_o, 32'h4);
    stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("stl_hold", {pc_o, inst_o}, {32'h4, mem_word(32'h4)});
      check("stl_hold_valid", valid_o, 1);
    end
    stall_i = 1'b0;
    step();
    check("stl_d8", pc_o, 32'h8);
    check("stl_count", deliv, base + 3);

    // Redirect while WAIT on 0x100
    jump_to(32'h100);
    push_exp(32'h200);
    base = deliv;
    step();
    check("rw_issue_addr", if_addr_o, 32'h100);
    step();
    check("rw_accept", if_re_o, 0);
    step();
    jump_i = 1'b1;
    jump_addr_i = 32'h203;
    step();
    jump_i = 1'b0;
    check("rw_valid", valid_o, 0);
    check("rw_still_wait", if_re_o, 0);
    done_seen = 1'b0;
    k = 0;
    while (!if_re_o && k < 20) begin
      step();
      if (mc_done_i) done_seen = 1'b1;
      k++;
    end
    check("rw_done_before_req", done_seen, 1);
    check("rw_next_addr", if_addr_o, 32'h200);
    wait_deliv("rw_deliv", base + 1, 30);

    // Aliasing on index 0
    fetch("al_000", 32'h0, 1);
    check("al_000_miss", re_seen, 1);
    fetch("al_100", 32'h100, 1);
    check("al_100_miss", re_seen, 1);
    fetch("al_000_again", 32'h0, 1);
    check("al_000_remiss", re_seen, 1);

    // Reset while WAIT on 0x300; orphan done must not fill
    jump_to(32'h300);
    step();
    step();
    check("rs_in_wait", if_re_o, 0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rs_valid", valid_o, 0);
    check("rs_inst", inst_o, 0);
    check("rs_pc", pc_o, 0);
    check("rs_re", if_re_o, 0);
    check("rs_addr", if_addr_o, 0);
    push_exp(32'h0);
    base = deliv;
    wait_deliv("rs_deliv0", base + 1, 40);
    fetch("rs_300", 32'h300, 1);
    check("rs_300_miss", re_seen, 1);

    step();
    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
